// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if
// Bundles the sweeper's request, stimulus, response and status signals.
//   start           - one-cycle sweep request (toward the sweeper)
//   A,B,C,D         - stimulus vector {A,B,C,D} (from the sweeper)
//   F               - downstream boolean stage response (toward the sweeper)
//   busy, done      - sweep in progress / sweep complete
//   pass            - sweep finished with no mismatches (valid while done)
//   err_count       - mismatching vectors in the current or last sweep
//   first_err_vec   - vector of the first mismatch
//   first_err_valid - first_err_vec holds a captured value
//   cov_mask        - bit n set once vector n has been sampled
// Modports: slave = the sweeper itself, master = whoever requests sweeps
// and models the downstream stage.
interface truth_table_sweeper_if;
  logic        start;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        F;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_err_vec;
  logic        first_err_valid;
  logic [15:0] cov_mask;

  modport slave (
    input  start, F,
    output A, B, C, D, busy, done, pass, err_count,
           first_err_vec, first_err_valid, cov_mask
  );

  modport master (
    output start, F,
    input  A, B, C, D, busy, done, pass, err_count,
           first_err_vec, first_err_valid, cov_mask
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Walks the 16 input vectors {A,B,C,D} = 0000..1111 through a downstream
// boolean stage, holding each vector SETTLE_CYCLES+1 cycles and sampling F
// on the last edge of the hold. F is checked against (B&D)|(~B&~D); the
// mismatch count, first failing vector and sampled-vector coverage are kept.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - truth_table_sweeper_if.slave (start/F in, stimulus and status out)
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  truth_table_sweeper_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  hold_q, hold_d;
  logic [4:0]  err_count_q, err_count_d;
  logic [3:0]  first_err_vec_q, first_err_vec_d;
  logic        first_err_valid_q, first_err_valid_d;
  logic [15:0] cov_mask_q, cov_mask_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        expected_s;
  logic        mismatch_s;

  // Next-state, sweep bookkeeping and registered-output decode.
  always_comb begin
    state_d           = state_q;
    vec_d             = vec_q;
    hold_d            = hold_q;
    err_count_d       = err_count_q;
    first_err_vec_d   = first_err_vec_q;
    first_err_valid_d = first_err_valid_q;
    cov_mask_d        = cov_mask_q;
    // Expected response is B XNOR D of the vector currently on the pins.
    expected_s        = ~(vec_q[2] ^ vec_q[0]);
    mismatch_s        = (bus.F != expected_s);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d           = SETTLE;
          vec_d             = 4'd0;
          hold_d            = HOLD_LOAD;
          err_count_d       = 5'd0;
          first_err_vec_d   = 4'd0;
          first_err_valid_d = 1'b0;
          cov_mask_d        = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      SETTLE: begin
        // hold_q reaching zero marks the final edge of this vector's hold.
        if (hold_q == 4'd0) begin
          cov_mask_d = cov_mask_q | (16'd1 << vec_q);
          if (mismatch_s) begin
            err_count_d = err_count_q + 5'd1;
            if (!first_err_valid_q) begin
              first_err_vec_d   = vec_q;
              first_err_valid_d = 1'b1;
            end else begin
              first_err_vec_d   = first_err_vec_q;
            end
          end else begin
            err_count_d = err_count_q;
          end
          if (vec_q == 4'hF) begin
            state_d = DONE;
            vec_d   = 4'd0;
          end else begin
            vec_d  = vec_q + 4'd1;
            hold_d = HOLD_LOAD;
          end
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = 4'd0;
      end
    endcase

    busy_d = (state_d == SETTLE);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_count_d == 5'd0);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      vec_q             <= 4'd0;
      hold_q            <= 4'd0;
      err_count_q       <= 5'd0;
      first_err_vec_q   <= 4'd0;
      first_err_valid_q <= 1'b0;
      cov_mask_q        <= 16'd0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      hold_q            <= hold_d;
      err_count_q       <= err_count_d;
      first_err_vec_q   <= first_err_vec_d;
      first_err_valid_q <= first_err_valid_d;
      cov_mask_q        <= cov_mask_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
    end
  end

  assign bus.A               = vec_q[3];
  assign bus.B               = vec_q[2];
  assign bus.C               = vec_q[1];
  assign bus.D               = vec_q[0];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_vec   = first_err_vec_q;
  assign bus.first_err_valid = first_err_valid_q;
  assign bus.cov_mask        = cov_mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Scoreboard bench for truth_table_sweeper: one instance with SETTLE_CYCLES=1
// and one with SETTLE_CYCLES=3. The downstream stage is modelled here
// (correct, stuck-at-0, inverted, or random per-vector faults).
module tb_truth_table_sweeper;

  typedef struct {
    int done_cyc;
    int err;
    int fvec;
    int fvalid;
    int pass;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start1;
  logic        start3;
  int          mode1;
  int          mode3;
  logic [15:0] mask1;
  logic [15:0] mask3;
  int          cyc;
  int          checks;
  int          errors;
  exp_t        q1[$];
  exp_t        q3[$];
  exp_t        me1;
  exp_t        me3;
  logic        prev1;
  logic        prev3;

  truth_table_sweeper_if bus1();
  truth_table_sweeper_if bus3();

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  truth_table_sweeper #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // Expected truth-table value for vector n = {A,B,C,D}: F = 1 iff B == D.
  function automatic logic e_of(input int n);
    return logic'(((n >> 2) & 1) == (n & 1));
  endfunction

  // Downstream stage behaviour under each fault mode.
  function automatic logic f_of(input int mode, input logic [15:0] mask, input int n);
    case (mode)
      0: return e_of(n);
      1: return 1'b0;
      2: return ~e_of(n);
      default: return e_of(n) ^ mask[n];
    endcase
  endfunction

  // Outcome of a whole sweep, computed from the truth table alone.
  function automatic exp_t model(input int mode, input logic [15:0] mask, input int s, input int k);
    exp_t r;
    r.err = 0; r.fvec = 0; r.fvalid = 0;
    for (int n = 0; n < 16; n++) begin
      if (f_of(mode, mask, n) != e_of(n)) begin
        if (r.fvalid == 0) begin
          r.fvec = n;
          r.fvalid = 1;
        end
        r.err++;
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    r.done_cyc = k + 16 * (s + 1);
    return r;
  endfunction

  assign bus1.start = start1;
  assign bus3.start = start3;
  assign bus1.F = f_of(mode1, mask1, int'({bus1.A, bus1.B, bus1.C, bus1.D}));
  assign bus3.F = f_of(mode3, mask3, int'({bus3.A, bus3.B, bus3.C, bus3.D}));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard when done rises and checks invariants every cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev1 = 1'b0;
      prev3 = 1'b0;
    end else begin
      cmp("busy_done_excl1", 32'(bus1.busy & bus1.done), 32'd0);
      cmp("pass_needs_done1", 32'(bus1.pass & ~bus1.done), 32'd0);
      cmp("busy_done_excl3", 32'(bus3.busy & bus3.done), 32'd0);
      if (bus1.done && !prev1) begin
        if (q1.size() == 0) begin
          cmp("unexpected_done1", 32'd1, 32'd0);
        end else begin
          me1 = q1.pop_front();
          cmp("done_cycle1", cyc, me1.done_cyc);
          cmp("err_count1", 32'(bus1.err_count), me1.err);
          cmp("first_err_vec1", 32'(bus1.first_err_vec), me1.fvec);
          cmp("first_err_valid1", 32'(bus1.first_err_valid), me1.fvalid);
          cmp("pass1", 32'(bus1.pass), me1.pass);
          cmp("cov_mask1", 32'(bus1.cov_mask), 32'hFFFF);
          cmp("vec_after_done1", 32'({bus1.A, bus1.B, bus1.C, bus1.D}), 32'd0);
        end
      end
      if (bus3.done && !prev3) begin
        if (q3.size() == 0) begin
          cmp("unexpected_done3", 32'd1, 32'd0);
        end else begin
          me3 = q3.pop_front();
          cmp("done_cycle3", cyc, me3.done_cyc);
          cmp("err_count3", 32'(bus3.err_count), me3.err);
          cmp("first_err_vec3", 32'(bus3.first_err_vec), me3.fvec);
          cmp("pass3", 32'(bus3.pass), me3.pass);
          cmp("cov_mask3", 32'(bus3.cov_mask), 32'hFFFF);
        end
      end
      prev1 = bus1.done;
      prev3 = bus3.done;
    end
  end

  task automatic start_sweep(input int which, input int mode, input logic [15:0] mask);
    @(negedge clk);
    if (which == 1) begin
      mode1 = mode; mask1 = mask; start1 = 1'b1;
      q1.push_back(model(mode, mask, 1, cyc + 1));
    end else begin
      mode3 = mode; mask3 = mask; start3 = 1'b1;
      q3.push_back(model(mode, mask, 3, cyc + 1));
    end
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int which);
    int  n;
    logic seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = (which == 1) ? bus1.done : bus3.done;
    end
    if (!seen) cmp("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_vec1(input logic [3:0] target);
    int  n;
    logic seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = ({bus1.A, bus1.B, bus1.C, bus1.D} == target);
    end
    if (!seen) cmp("vec_timeout", 32'd0, 32'(target));
  endtask

  task automatic chk_reset1(input string tag);
    cmp({tag, "_vec"}, 32'({bus1.A, bus1.B, bus1.C, bus1.D}), 32'd0);
    cmp({tag, "_busy"}, 32'(bus1.busy), 32'd0);
    cmp({tag, "_done"}, 32'(bus1.done), 32'd0);
    cmp({tag, "_pass"}, 32'(bus1.pass), 32'd0);
    cmp({tag, "_err_count"}, 32'(bus1.err_count), 32'd0);
    cmp({tag, "_first_err_vec"}, 32'(bus1.first_err_vec), 32'd0);
    cmp({tag, "_first_err_valid"}, 32'(bus1.first_err_valid), 32'd0);
    cmp({tag, "_cov_mask"}, 32'(bus1.cov_mask), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    mode1 = 0; mode3 = 0; mask1 = 16'd0; mask3 = 16'd0;
    prev1 = 1'b0; prev3 = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset1("reset");
    rst = 1'b0;

    // Correct, stuck-at-0 and inverted downstream stages.
    start_sweep(1, 0, 16'd0);
    wait_done(1);
    start_sweep(1, 1, 16'd0);
    wait_done(1);
    start_sweep(1, 2, 16'd0);
    wait_done(1);

    // Random per-vector fault patterns.
    for (int i = 0; i < 4; i++) begin
      start_sweep(1, 3, 16'($urandom_range(0, 65535)));
      wait_done(1);
    end

    // Start accepted from DONE after a failing sweep clears everything.
    start_sweep(1, 1, 16'd0);
    wait_done(1);
    start_sweep(1, 0, 16'd0);
    cmp("restart_busy", 32'(bus1.busy), 32'd1);
    cmp("restart_done", 32'(bus1.done), 32'd0);
    cmp("restart_err_count", 32'(bus1.err_count), 32'd0);
    cmp("restart_first_err_valid", 32'(bus1.first_err_valid), 32'd0);
    cmp("restart_cov_mask", 32'(bus1.cov_mask), 32'd0);
    cmp("restart_vec", 32'({bus1.A, bus1.B, bus1.C, bus1.D}), 32'd0);
    wait_done(1);

    // Start during SETTLE is ignored: done still at the original deadline.
    start_sweep(1, 3, 16'h8421);
    wait_vec1(4'b0011);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1);

    // Reset mid-sweep at vector 0101 abandons the sweep immediately.
    start_sweep(1, 2, 16'd0);
    wait_vec1(4'b0101);
    #2 rst = 1'b1;
    #1 chk_reset1("midreset");
    if (q1.size() > 0) q1.delete(q1.size() - 1);
    @(negedge clk);
    rst = 1'b0;
    start_sweep(1, 0, 16'd0);
    wait_done(1);

    // Longer settle time.
    start_sweep(3, 0, 16'd0);
    wait_done(3);
    start_sweep(3, 3, 16'($urandom_range(0, 65535)));
    wait_done(3);

    repeat (4) @(negedge clk);
    cmp("q1_drained", q1.size(), 32'd0);
    cmp("q3_drained", q3.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of cycles each vector is held before F is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; the reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, a single-cycle request to begin a 16-vector sweep.
REQ-005 SHALL have ports A, B, C, D, each an output of 1 bit, forming the stimulus vector {A,B,C,D} driven to the downstream boolean stage.
REQ-006 SHALL have port F, input, 1 bit, the response of the downstream stage.
REQ-007 SHALL have port busy, output, 1 bit, high while a sweep is in progress.
REQ-008 SHALL have port done, output, 1 bit, high after sweep completion until the next accepted start.
REQ-009 SHALL have port pass, output, 1 bit, valid when done=1; it is 1 iff err_count=0.
REQ-010 SHALL have port err_count, output, 5 bits, the number of mismatching vectors in the current or last sweep.
REQ-011 SHALL have port first_err_vec, output, 4 bits, the {A,B,C,D} of the first mismatch.
REQ-012 SHALL have port first_err_valid, output, 1 bit, high once first_err_vec holds a captured value.
REQ-013 SHALL have port cov_mask, output, 16 bits; bit n is set when vector n has been sampled.

Function
REQ-014 SHALL implement an FSM with states IDLE, SETTLE, DONE.
REQ-015 SHALL accept start only in IDLE or DONE, and SHALL ignore start while in SETTLE.
REQ-016 On accepting start at edge k, SHALL:
- clear err_count, first_err_valid, first_err_vec and cov_mask;
- drive {A,B,C,D}=0000;
- load the hold counter with SETTLE_CYCLES;
- enter SETTLE.
REQ-017 In SETTLE, the hold counter SHALL decrement every cycle; each vector n SHALL be held for exactly SETTLE_CYCLES+1 cycles, occupying edges k+n(S+1) to k+(n+1)(S+1), where S=SETTLE_CYCLES.
REQ-018 At the final edge of each hold, SHALL do all of the following on that same edge:
- sample F;
- compare F to the expected value E=(B&D)|(~B&~D) computed from the currently driven vector;
- set cov_mask[n].
REQ-019 On a mismatch (F!=E), SHALL increment err_count; if first_err_valid=0, SHALL also capture first_err_vec=n and set first_err_valid=1 on that edge.
REQ-020 If n<15, SHALL advance the vector to n+1 on the sample edge and reload the hold counter.
REQ-021 If n=15, SHALL enter DONE on the sample edge; the vector SHALL never wrap past 1111 within a sweep.
REQ-022 In DONE, SHALL hold done=1, drive {A,B,C,D}=0000, and keep err_count, first_err_vec, first_err_valid and cov_mask stable.
REQ-023 busy SHALL be 1 exactly in SETTLE; done SHALL be 1 exactly in DONE; busy and done SHALL never both be 1.
REQ-024 A sweep SHALL complete with done rising at edge k+16(S+1).
REQ-025 err_count SHALL range 0..16 and need no saturation logic.
REQ-026 pass SHALL be 0 whenever done=0.
REQ-027 All outputs SHALL be registered; F is the only combinational input to the comparison.

Reset
REQ-028 While rst=1, regardless of clk, SHALL force:
- state=IDLE;
- {A,B,C,D}=0000;
- busy=0, done=0, pass=0;
- err_count=0, first_err_vec=0000, first_err_valid=0, cov_mask=0x0000.
REQ-029 Reset asserted mid-sweep SHALL abandon the sweep with no partial results retained; the first start after rst deasserts SHALL begin a fresh sweep at vector 0000.

Verification
REQ-030 Correct DUT, S=1: start at edge k -> done rises at k+32, pass=1, err_count=0, cov_mask=0xFFFF, first_err_valid=0.
REQ-031 F stuck at 0: full sweep -> err_count=8, first_err_vec=0000, first_err_valid=1, pass=0, cov_mask=0xFFFF.
REQ-032 F driven as ~E (inverted DUT): full sweep -> err_count=16, first_err_vec=0000, pass=0.
REQ-033 rst pulsed while vector 0101 is driven -> all outputs take their reset values immediately; a subsequent start yields a clean sweep with done at +32 cycles.
REQ-034 start pulsed during SETTLE at vector 0011 -> no restart, done at the original k+32; start while in DONE -> counters and cov_mask cleared, vector 0000, busy=1 next cycle.
REQ-035 S=3 with a correct DUT -> each vector held 4 cycles, done at k+64, pass=1.
